demux_8_des: RTL and testbench

Serial-to-parallel deserializer and the receive-side counterpart of the team's 8:1 bit-select multiplexer. It accepts one bit per handshake and steers each bit into a byte slot chosen by an internal 3-bit select counter, so bit k of a word lands in dout[k] (LSB first). It presents each completed byte on a valid/ready output port. A one-word output holding register lets the next byte assemble while the previous byte waits for the consumer.

---
 rtl/demux_8_des_if.sv | 31 +++
 rtl/demux_8_des.sv | 117 +++++++++++
 tb/tb_demux_8_des.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/demux_8_des_if.sv
// Bundle of the serial-in / byte-out signals of demux_8_des.
// Latency: none; this is wiring only.
// Backpressure: din_ready toward the bit source, dout_ready from the byte consumer.
// Ports (slave = deserializer view):
//   din, din_valid, clr, dout_ready      -> into the deserializer
//   din_ready, sel, dout, dout_valid     <- out of the deserializer
interface demux_8_des_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic             din;
  logic             din_valid;
  logic             din_ready;
  logic             clr;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  // Bit source and byte consumer side.
  modport master (
    output din, din_valid, clr, dout_ready,
    input  din_ready, sel, dout, dout_valid
  );

  // Deserializer side.
  modport slave (
    input  din, din_valid, clr, dout_ready,
    output din_ready, sel, dout, dout_valid
  );
endinterface

// File: rtl/demux_8_des.sv
// Serial-to-parallel deserializer: bit k of each word lands in dout[k], LSB first.
// Latency: dout/dout_valid are updated on the same edge that accepts the 8th bit.
// Backpressure: stalls only the 8th bit while a previous word is still unconsumed.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : demux_8_des_if.slave (din/din_valid/din_ready, clr, sel,
//              dout/dout_valid/dout_ready)
module demux_8_des #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  demux_8_des_if.slave   bus
);

  // This block is fixed at one byte with a 3-bit slot counter.
  if (WIDTH != 8 || SEL_W != 3) begin : g_bad_params
    $error("demux_8_des supports only WIDTH=8, SEL_W=3");
  end

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [SEL_W-1:0] cnt;
  logic [WIDTH-1:0] dout_q;

  logic             last_slot;
  logic             out_full;
  logic             din_ready_c;
  logic             xfer;
  logic             word_done;
  logic             consume;

  assign last_slot = (cnt == LAST_SLOT);
  assign out_full  = (state == FULL);

  // Only the final bit needs room in the holding register; bits 0..6 go into
  // acc and are always accepted. clr blocks acceptance outright.
  assign din_ready_c = !bus.clr && !(last_slot && out_full && !bus.dout_ready);

  assign xfer      = bus.din_valid && din_ready_c;
  assign word_done = xfer && last_slot;
  assign consume   = out_full && bus.dout_ready;

  // Assembly register and slot counter. cnt wraps 7 -> 0 by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (bus.clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (xfer) begin
      cnt <= cnt + SEL_W'(1);
      if (last_slot) begin
        // Completed word moves to dout; start the next one from zero.
        acc <= '0;
      end else begin
        acc[cnt] <= bus.din;
      end
    end
  end

  // Output word register: only a completing transfer writes it, so it holds
  // its last value while the output is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else if (word_done) begin
      dout_q <= {bus.din, acc[WIDTH-2:0]};
    end
  end

  // Output occupancy FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Output occupancy FSM: next state. A completion on the same edge as a
  // consumption refills the register, so FULL persists.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (word_done) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (consume && !word_done) begin
          state_nxt = EMPTY;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  assign bus.din_ready  = din_ready_c;
  assign bus.sel        = cnt;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = out_full;

endmodule

// File: tb/tb_demux_8_des.sv
// Directed bench for demux_8_des: table-driven vectors plus hand-written
// sequences for random gaps and asynchronous reset.
module tb_demux_8_des;

  logic clk;
  logic rst;

  demux_8_des_if #(.WIDTH(8), .SEL_W(3)) bus ();

  demux_8_des #(.WIDTH(8), .SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       din;
    logic       din_valid;
    logic       clr;
    logic       dout_ready;
    logic       exp_din_ready;  // combinational, before the edge
    logic [2:0] exp_sel;        // after the edge
    logic       exp_dout_valid; // after the edge
    logic [7:0] exp_dout;       // after the edge
  } vec_t;

  vec_t vecs[$];
  int   total;
  int   bad;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic d, input logic v, input logic c, input logic r,
                     input logic er, input logic [2:0] es, input logic ev,
                     input logic [7:0] eo);
    vec_t t;
    t.din = d; t.din_valid = v; t.clr = c; t.dout_ready = r;
    t.exp_din_ready = er; t.exp_sel = es; t.exp_dout_valid = ev; t.exp_dout = eo;
    vecs.push_back(t);
  endtask

  // First n bits of word w, all accepted. While mid-word the output shows
  // (dv_mid, dout_mid); the 8th bit, if sent, completes w.
  task automatic add_bits(input logic [7:0] w, input int n, input logic r,
                          input logic dv_mid, input logic [7:0] dout_mid);
    for (int i = 0; i < n; i++) begin
      if (i == 7) add(w[i], 1'b1, 1'b0, r, 1'b1, 3'd0, 1'b1, w);
      else        add(w[i], 1'b1, 1'b0, r, 1'b1, 3'(i + 1), dv_mid, dout_mid);
    end
  endtask

  task automatic apply(input string tag, input int idx, input vec_t v);
    bus.din        = v.din;
    bus.din_valid  = v.din_valid;
    bus.clr        = v.clr;
    bus.dout_ready = v.dout_ready;
    #1;
    chk($sformatf("%s[%0d].din_ready", tag, idx), 8'(bus.din_ready), 8'(v.exp_din_ready));
    @(posedge clk);
    #1;
    chk($sformatf("%s[%0d].sel", tag, idx), 8'(bus.sel), 8'(v.exp_sel));
    chk($sformatf("%s[%0d].dout_valid", tag, idx), 8'(bus.dout_valid), 8'(v.exp_dout_valid));
    chk($sformatf("%s[%0d].dout", tag, idx), bus.dout, v.exp_dout);
  endtask

  logic [7:0] words[16];
  logic [7:0] got[$];
  logic       took;
  int         bi;
  int         cycles;
  vec_t       tv;

  initial begin
    total = 0;
    bad   = 0;
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.clr = 1'b0; bus.dout_ready = 1'b0;

    // ---- reset state ----
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst.sel", 8'(bus.sel), 8'd0);
    chk("rst.dout", bus.dout, 8'h00);
    chk("rst.dout_valid", 8'(bus.dout_valid), 8'd0);
    chk("rst.din_ready", 8'(bus.din_ready), 8'd1);
    @(posedge clk);
    #1;

    // ---- vector table ----
    // 0xA5 from reset, then one idle cycle: single-cycle valid pulse.
    add_bits(8'hA5, 8, 1'b1, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'hA5);
    // Back-to-back 0x3C, 0xC3 with consumer always ready.
    add_bits(8'h3C, 8, 1'b1, 1'b0, 8'hA5);
    add_bits(8'hC3, 8, 1'b1, 1'b0, 8'h3C);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'hC3);
    // Backpressure: 0x11 held, 7 bits of 0x22 still accepted, 8th stalls.
    add_bits(8'h11, 8, 1'b0, 1'b0, 8'hC3);
    add_bits(8'h22, 7, 1'b0, 1'b1, 8'h11);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 8'h11);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 8'h11);
    // Consume 0x11 and load 0x22 on the same edge.
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 8'h22);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h22);
    // clr resync: 3 bits, clr with a 0 bit offered (dropped), then 0xFF.
    add_bits(8'hFF, 3, 1'b1, 1'b0, 8'h22);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h22);
    add_bits(8'hFF, 8, 1'b1, 1'b0, 8'h22);
    // clr leaves a held word alone.
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'hFF);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'hFF);

    for (int i = 0; i < vecs.size(); i++) begin
      apply("tbl", i, vecs[i]);
    end

    // ---- random gaps over 16 random words ----
    for (int i = 0; i < 16; i++) words[i] = 8'($urandom);
    bi = 0;
    cycles = 0;
    while ((bi < 128 || got.size() < 16) && cycles < 3000) begin
      bus.clr = 1'b0;
      if (bi < 128) begin
        bus.din_valid  = 1'($urandom_range(0, 1));
        bus.din        = words[bi / 8][bi % 8];
        bus.dout_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.din_valid  = 1'b0;
        bus.din        = 1'b0;
        bus.dout_ready = 1'b1;
      end
      #1;
      took = bus.din_valid && bus.din_ready;
      if (bus.dout_valid && bus.dout_ready) got.push_back(bus.dout);
      @(posedge clk);
      #1;
      if (took) bi++;
      cycles++;
    end
    chk("rand.finished_in_budget", 8'(cycles < 3000), 8'd1);
    chk("rand.word_count", 8'(got.size()), 8'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < got.size()) chk($sformatf("rand.word[%0d]", i), got[i], words[i]);
      else                chk($sformatf("rand.word[%0d].missing", i), 8'hxx, words[i]);
    end

    // ---- asynchronous reset mid-word with a held word ----
    bus.din_valid = 1'b0; bus.dout_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      tv.din = 1'((8'h5A >> i) & 8'h01); tv.din_valid = 1'b1; tv.clr = 1'b0; tv.dout_ready = 1'b0;
      tv.exp_din_ready = 1'b1; tv.exp_sel = 3'(i + 1);
      tv.exp_dout_valid = (i == 7); tv.exp_dout = (i == 7) ? 8'h5A : bus.dout;
      apply("ar_fill", i, tv);
    end
    for (int i = 0; i < 3; i++) begin
      tv.din = 1'b1; tv.din_valid = 1'b1; tv.clr = 1'b0; tv.dout_ready = 1'b0;
      tv.exp_din_ready = 1'b1; tv.exp_sel = 3'(i + 1); tv.exp_dout_valid = 1'b1; tv.exp_dout = 8'h5A;
      apply("ar_part", i, tv);
    end
    bus.din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst.sel", 8'(bus.sel), 8'd0);
    chk("arst.dout", bus.dout, 8'h00);
    chk("arst.dout_valid", 8'(bus.dout_valid), 8'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      tv.din = 1'((8'h96 >> i) & 8'h01); tv.din_valid = 1'b1; tv.clr = 1'b0; tv.dout_ready = 1'b1;
      tv.exp_din_ready = 1'b1; tv.exp_sel = 3'((i + 1) % 8);
      tv.exp_dout_valid = (i == 7); tv.exp_dout = (i == 7) ? 8'h96 : 8'h00;
      apply("ar_after", i, tv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
